reset_sequencer: RTL

Parametrised board-level reset sequencer that converts the raw reset button and software reset requests into N staged, active-high, clock-synchronous reset outputs for downstream cores. It sits between the reset pin and `core`/peripheral instances in the board top, replacing the single-output reset generator. Stages release in order with a programmable gap, and an optional watchdog re-enters the sequence on software hang.

---
 rtl/reset_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged board reset generator with optional watchdog.
// Turns the raw reset pin and soft requests into N ordered, synchronous resets.
//
// Ports:
//   m_clock   in  system clock (single clock domain)
//   p_reset   in  synchronous active-high block reset
//   rst_req_n in  raw asynchronous reset request, active-low (synchronised here)
//   soft_req  in  synchronous software reset request (pulse or level)
//   wdt_kick  in  watchdog service strobe
//   rst_out   out per-stage active-high reset, bit 0 releases first
//   ready     out all stages released
//   wdt_fired out sticky: last reset came from the watchdog
//
// Build option: define RSTSEQ_WDT_EN to include the watchdog. Without it
// wdt_kick is ignored and wdt_fired is tied low.

module reset_sequencer #(
   parameter int N_STAGE     = 3,
   parameter int HOLD_CYCLES = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int SYNC_DEPTH  = 2,
   parameter int WDT_CYCLES  = 50000000
) (
   input  logic               m_clock,
   input  logic               p_reset,
   input  logic               rst_req_n,
   input  logic               soft_req,
   input  logic               wdt_kick,
   output logic [N_STAGE-1:0] rst_out,
   output logic               ready,
   output logic               wdt_fired
);

   localparam int HG_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
`ifdef RSTSEQ_WDT_EN
   localparam int CNT_MAX = (WDT_CYCLES > HG_MAX) ? WDT_CYCLES : HG_MAX;
`else
   localparam int CNT_MAX = HG_MAX;
`endif
   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGE - 1);

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_REL  = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [IW-1:0]        r_idx;
   logic [IW-1:0]        w_idx_nxt;
   logic [N_STAGE-1:0]   r_rst_out;
   logic [N_STAGE-1:0]   w_rst_nxt;
   logic                 r_ready;
   logic                 w_ready_nxt;
   logic [SYNC_DEPTH-1:0] r_sync;
   logic                 w_pin_req;
   logic                 w_wdt_expire;
   logic                 w_req;

   // Counters hold at all-ones rather than wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Pin synchroniser; resets to 0 so the pin reads as "request asserted".
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], rst_req_n};
      end
   end

   assign w_pin_req = ~r_sync[SYNC_DEPTH-1];
   assign w_req     = w_pin_req | soft_req | w_wdt_expire;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_rst_nxt   = r_rst_out;
      w_ready_nxt = r_ready;
      if (w_req) begin
         // Assertion is immediate from any state.
         w_state_nxt = S_HOLD;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
         w_rst_nxt   = '1;
         w_ready_nxt = 1'b0;
      end else begin
         unique case (r_state)
            S_HOLD: begin
               w_rst_nxt   = '1;
               w_ready_nxt = 1'b0;
               if (r_cnt == HOLD_LAST) begin
                  w_state_nxt  = S_REL;
                  w_cnt_nxt    = '0;
                  w_idx_nxt    = '0;
                  w_rst_nxt[0] = 1'b0;
               end else begin
                  w_cnt_nxt = sat_inc(r_cnt);
               end
            end
            S_REL: begin
               if (r_cnt == GAP_LAST) begin
                  w_cnt_nxt = '0;
                  if (r_idx == IDX_LAST) begin
                     w_state_nxt = S_RUN;
                     w_rst_nxt   = '0;
                     w_ready_nxt = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx + 1'b1;
                     for (int b = 0; b < N_STAGE; b++) begin
                        if (b == int'(r_idx) + 1) begin
                           w_rst_nxt[b] = 1'b0;
                        end
                     end
                  end
               end else begin
                  w_cnt_nxt = sat_inc(r_cnt);
               end
            end
            S_RUN: begin
               w_rst_nxt   = '0;
               w_ready_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_rst_nxt   = '1;
               w_ready_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_state   <= S_HOLD;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_rst_out <= '1;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_rst_out <= w_rst_nxt;
         r_ready   <= w_ready_nxt;
      end
   end

`ifdef RSTSEQ_WDT_EN
   logic [CW-1:0] r_wdt_cnt;
   logic          r_wdt_fired;

   localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);

   // A kick in the expiry cycle suppresses the fire.
   assign w_wdt_expire = (r_state == S_RUN) && (r_wdt_cnt == WDT_LAST)
                         && !wdt_kick;

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_wdt_cnt   <= '0;
         r_wdt_fired <= 1'b0;
      end else begin
         if (w_wdt_expire) begin
            r_wdt_fired <= 1'b1;
         end
         // Counts only while staying in RUN; leaving RUN or a kick clears it.
         if (r_state == S_RUN && w_state_nxt == S_RUN && !wdt_kick) begin
            r_wdt_cnt <= sat_inc(r_wdt_cnt);
         end else begin
            r_wdt_cnt <= '0;
         end
      end
   end

   assign wdt_fired = r_wdt_fired;
`else
   logic w_unused;

   assign w_wdt_expire = 1'b0;
   assign wdt_fired    = 1'b0;
   assign w_unused     = wdt_kick | (WDT_CYCLES == 0);
`endif

   assign rst_out = r_rst_out;
   assign ready   = r_ready;

endmodule
